// File: rtl/vsim_msg_pkg.sv
// vsim_msg_pkg
//   Shared definitions for the Verilator co-simulation message transport.
//   Imported by both the inbound sink packer and the outbound source stage,
//   so beat width and length encoding stay identical in both directions.
//   BEAT_WIDTH   : bits per host beat
//   LENGTH_WIDTH : bits of the data_length field (beats - 1)
//   msg_len_t    : type of the beat counter / length field
package vsim_msg_pkg;

    localparam int BEAT_WIDTH   = 32;
    localparam int LENGTH_WIDTH = 16;

    typedef logic [LENGTH_WIDTH-1:0] msg_len_t;

endpackage : vsim_msg_pkg

// File: rtl/vsim_sink_packer.sv
// vsim_sink_packer
//   Packs a stream of 32-bit host beats (low word first) into one
//   width-bit message, then offers it downstream with an EN/RDY handshake.
//
//   Ports:
//     CLK, RST_N      : clock, asynchronous active-low reset
//     beat_valid      : host beat present
//     beat_data       : beat payload
//     beat_last       : final beat of the current message
//     beat_ready      : beat accepted this cycle when beat_valid is high
//     RDY_data        : downstream can take a message
//     EN_data         : message transferred this cycle (RDY_data while holding)
//     data_v          : packed message, words above the last beat read zero
//     data_length     : beats received - 1
//     overflow        : sticky, a message carried more than width/32 beats
module vsim_sink_packer
    import vsim_msg_pkg::*;
#(
    parameter int width = 64
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    beat_valid,
    input  logic [BEAT_WIDTH-1:0]   beat_data,
    input  logic                    beat_last,
    output logic                    beat_ready,
    input  logic                    RDY_data,
    output logic                    EN_data,
    output logic [width-1:0]        data_v,
    output logic [LENGTH_WIDTH-1:0] data_length,
    output logic                    overflow
);

    localparam int       MAXBEATS   = width / BEAT_WIDTH;
    localparam msg_len_t MAXBEATS_L = msg_len_t'(MAXBEATS);

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [width-1:0] data_q, data_d;
    msg_len_t   cnt_q, cnt_d;      // beats accepted so far; also the next write index
    msg_len_t   len_q, len_d;
    logic       ovf_q, ovf_d;
    msg_len_t   cnt_inc;

    // Beat counter saturates so absurdly long messages cannot wrap the length.
    function automatic msg_len_t sat_inc(input msg_len_t v);
        return (v == '1) ? v : v + msg_len_t'(1);
    endfunction

    assign cnt_inc = sat_inc(cnt_q);

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        ovf_d      = ovf_q;
        beat_ready = 1'b0;
        EN_data    = 1'b0;
        unique case (state_q)
            COLLECT: begin
                beat_ready = 1'b1;
                if (beat_valid) begin
                    for (int b = 0; b < MAXBEATS; b++) begin
                        if (cnt_q == msg_len_t'(b))
                            data_d[b*BEAT_WIDTH +: BEAT_WIDTH] = beat_data;
                    end
                    // Beats past the register width are dropped but still counted.
                    if (cnt_q >= MAXBEATS_L)
                        ovf_d = 1'b1;
                    cnt_d = cnt_inc;
                    if (beat_last) begin
                        len_d   = cnt_inc - msg_len_t'(1);
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Registers frozen until delivery; then clear for the next message.
                EN_data = RDY_data;
                if (RDY_data) begin
                    state_d = COLLECT;
                    data_d  = '0;
                    cnt_d   = '0;
                    len_d   = '0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= COLLECT;
            data_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_v      = data_q;
    assign data_length = len_q;
    assign overflow    = ovf_q;

endmodule : vsim_sink_packer
